// File: rtl/apb_exe_pkg.sv
// Shared state type, transfer indices and APB address map for the
// execution-unit job sequencer (apb_master_exe_seq).
package apb_exe_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_SETTLE,
        ST_DONE
    } state_e;

    typedef logic [2:0] xfer_idx_t;

    localparam int unsigned ADDR_OPER   = 0;
    localparam int unsigned ADDR_ARGA   = 1;
    localparam int unsigned ADDR_ARGB   = 2;
    localparam int unsigned ADDR_RESULT = 0;
    localparam int unsigned ADDR_STATUS = 1;

    localparam int unsigned XFER_COUNT = 5;

    localparam xfer_idx_t IDX_OPER   = 3'd0;
    localparam xfer_idx_t IDX_ARGA   = 3'd1;
    localparam xfer_idx_t IDX_ARGB   = 3'd2;
    localparam xfer_idx_t IDX_RESULT = 3'd3;
    localparam xfer_idx_t IDX_STATUS = xfer_idx_t'(XFER_COUNT - 1);

    function automatic int unsigned xfer_addr(input xfer_idx_t idx);
        int unsigned addr;
        case (idx)
            IDX_OPER:   addr = ADDR_OPER;
            IDX_ARGA:   addr = ADDR_ARGA;
            IDX_ARGB:   addr = ADDR_ARGB;
            IDX_RESULT: addr = ADDR_RESULT;
            IDX_STATUS: addr = ADDR_STATUS;
            default:    addr = 0;
        endcase
        return addr;
    endfunction

    // Transfers 0..2 load the operands; 3..4 fetch the outcome.
    function automatic logic xfer_is_write(input xfer_idx_t idx);
        return idx <= IDX_ARGB;
    endfunction

endpackage

// File: rtl/apb_mst_wdog.sv
// ACCESS-phase watchdog: counts ACCESS cycles since the last SETUP and
// flags the cycle on which the TIMEOUT_CYCLES-th wait would end.
module apb_mst_wdog #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expired = run && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/apb_master_exe_seq.sv
// APB master that runs one execution-unit job: three operand writes, a settle
// gap, then result/status reads. Define APB_MST_TIMEOUT_EN for an ACCESS watchdog.
module apb_master_exe_seq
    import apb_exe_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 16,
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  i_PCLK,
    input  logic                  i_PRESET,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic [DATA_WIDTH-1:0] i_cmd_oper,
    input  logic [DATA_WIDTH-1:0] i_cmd_argA,
    input  logic [DATA_WIDTH-1:0] i_cmd_argB,
    output logic                  o_res_valid,
    input  logic                  i_res_ready,
    output logic [DATA_WIDTH-1:0] o_res_data,
    output logic [3:0]            o_res_status,
    output logic                  o_res_err,
    output logic [ADDR_WIDTH-1:0] o_PADDR,
    output logic                  o_PSEL,
    output logic                  o_PENABLE,
    output logic                  o_PWRITE,
    output logic [DATA_WIDTH-1:0] o_PWDATA,
    input  logic                  i_PREADY,
    input  logic [DATA_WIDTH-1:0] i_PRDATA,
    input  logic                  i_PSLVERR
);

    localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    state_e                state_q,      state_d;
    xfer_idx_t             idx_q,        idx_d;
    logic [SETTLE_W-1:0]   settle_cnt_q, settle_cnt_d;
    logic [DATA_WIDTH-1:0] oper_q,       oper_d;
    logic [DATA_WIDTH-1:0] arga_q,       arga_d;
    logic [DATA_WIDTH-1:0] argb_q,       argb_d;
    logic                  psel_q,       psel_d;
    logic                  penable_q,    penable_d;
    logic                  pwrite_q,     pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q,      paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q,     pwdata_d;
    logic                  cmd_ready_q,  cmd_ready_d;
    logic                  res_valid_q,  res_valid_d;
    logic [DATA_WIDTH-1:0] res_data_q,   res_data_d;
    logic [3:0]            res_status_q, res_status_d;
    logic                  err_q,        err_d;

`ifdef APB_MST_TIMEOUT_EN
    logic wdog_expired;

    apb_mst_wdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .clk     (i_PCLK),
        .rst     (i_PRESET),
        .clear   (state_q == ST_SETUP),
        .run     (state_q == ST_ACCESS),
        .expired (wdog_expired)
    );
`endif

    // NOTE: every always_comb output is defaulted first so no path leaves a
    // variable unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        settle_cnt_d = settle_cnt_q;
        oper_d       = oper_q;
        arga_d       = arga_q;
        argb_d       = argb_q;
        res_data_d   = res_data_q;
        res_status_d = res_status_q;
        err_d        = err_q;
        psel_d       = 1'b0;
        penable_d    = 1'b0;
        pwrite_d     = 1'b0;
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;

        case (state_q)
            ST_IDLE: begin
                if (i_cmd_valid && cmd_ready_q) begin
                    oper_d       = i_cmd_oper;
                    arga_d       = i_cmd_argA;
                    argb_d       = i_cmd_argB;
                    res_data_d   = '0;
                    res_status_d = '0;
                    err_d        = 1'b0;
                    idx_d        = IDX_OPER;
                    state_d      = ST_SETUP;
                end
            end
            ST_SETUP: state_d = ST_ACCESS;
            ST_ACCESS: begin
                if (i_PREADY) begin
                    if (i_PSLVERR) err_d = 1'b1;
                    if (idx_q == IDX_RESULT) res_data_d = i_PRDATA;
                    if (idx_q == IDX_STATUS) res_status_d = i_PRDATA[3:0];
                    if (idx_q == IDX_ARGB) begin
                        if (SETTLE_CYCLES == 0) begin
                            idx_d   = IDX_RESULT;
                            state_d = ST_SETUP;
                        end else begin
                            settle_cnt_d = '0;
                            state_d      = ST_SETTLE;
                        end
                    end else if (idx_q == IDX_STATUS) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = ST_SETUP;
                    end
                end
`ifdef APB_MST_TIMEOUT_EN
                // A stuck slave abandons the rest of the job; unread fields stay 0.
                else if (wdog_expired) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
`endif
            end
            ST_SETTLE: begin
                if (settle_cnt_q == SETTLE_W'(SETTLE_CYCLES - 1)) begin
                    idx_d   = IDX_RESULT;
                    state_d = ST_SETUP;
                end else begin
                    settle_cnt_d = settle_cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (i_res_ready) begin
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it.
        cmd_ready_d = (state_d == ST_IDLE);
        res_valid_d = (state_d == ST_DONE);
        if (state_d == ST_SETUP || state_d == ST_ACCESS) begin
            psel_d    = 1'b1;
            penable_d = (state_d == ST_ACCESS);
            pwrite_d  = xfer_is_write(idx_d);
            paddr_d   = ADDR_WIDTH'(xfer_addr(idx_d));
            case (idx_d)
                IDX_OPER: pwdata_d = oper_d;
                IDX_ARGA: pwdata_d = arga_d;
                IDX_ARGB: pwdata_d = argb_d;
                default:  pwdata_d = pwdata_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update
    // together from values sampled at the same edge.
    always_ff @(posedge i_PCLK) begin
        if (i_PRESET) begin
            state_q      <= ST_IDLE;
            idx_q        <= IDX_OPER;
            settle_cnt_q <= '0;
            oper_q       <= '0;
            arga_q       <= '0;
            argb_q       <= '0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            cmd_ready_q  <= 1'b0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_status_q <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            settle_cnt_q <= settle_cnt_d;
            oper_q       <= oper_d;
            arga_q       <= arga_d;
            argb_q       <= argb_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            pwrite_q     <= pwrite_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
            cmd_ready_q  <= cmd_ready_d;
            res_valid_q  <= res_valid_d;
            res_data_q   <= res_data_d;
            res_status_q <= res_status_d;
            err_q        <= err_d;
        end
    end

    assign o_cmd_ready  = cmd_ready_q;
    assign o_res_valid  = res_valid_q;
    assign o_res_data   = res_data_q;
    assign o_res_status = res_status_q;
    assign o_res_err    = err_q;
    assign o_PADDR      = paddr_q;
    assign o_PSEL       = psel_q;
    assign o_PENABLE    = penable_q;
    assign o_PWRITE     = pwrite_q;
    assign o_PWDATA     = pwdata_q;

endmodule

// File: tb/tb_apb_master_exe_seq.sv
// Self-checking bench for apb_master_exe_seq with a behavioural exe-unit APB
// slave; timeout scenario runs only when APB_MST_TIMEOUT_EN is defined.
module tb_apb_master_exe_seq;

    localparam int DW       = 8;
    localparam int AW       = 16;
    localparam int SETTLE   = 2;
    localparam int TIMEOUT  = 16;
    localparam int BASE_LAT = 5 * 3 + SETTLE + 1;

    typedef struct {
        int unsigned addr;
        bit          wr;
        int unsigned data;
    } xfer_t;

    logic          clk = 1'b0;
    logic          preset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [DW-1:0] cmd_oper = '0, cmd_arga = '0, cmd_argb = '0;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [DW-1:0] res_data;
    logic [3:0]    res_status;
    logic          res_err;
    logic [AW-1:0] paddr;
    logic          psel, penable, pwrite;
    logic [DW-1:0] pwdata;
    logic          pready = 1'b0;
    logic [DW-1:0] prdata = '0;
    logic          pslverr = 1'b0;

    int checks = 0;
    int errors = 0;

    // Slave configuration and observations
    xfer_t         log_q[$];
    int            stab_bad = 0;
    bit            stall = 0;
    int unsigned   wait_addr = 99;
    bit            wait_write = 0;
    int            wait_extra = 0;
    bit            slverr_en = 0;
    int unsigned   slverr_addr = 0;
    bit            slverr_write = 0;
    logic [DW-1:0] reg_oper = '0, reg_a = '0, reg_b = '0;

    always #5 clk = ~clk;

    apb_master_exe_seq #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .i_PCLK(clk), .i_PRESET(preset),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
        .i_cmd_oper(cmd_oper), .i_cmd_argA(cmd_arga), .i_cmd_argB(cmd_argb),
        .o_res_valid(res_valid), .i_res_ready(res_ready),
        .o_res_data(res_data), .o_res_status(res_status), .o_res_err(res_err),
        .o_PADDR(paddr), .o_PSEL(psel), .o_PENABLE(penable), .o_PWRITE(pwrite),
        .o_PWDATA(pwdata), .i_PREADY(pready), .i_PRDATA(prdata), .i_PSLVERR(pslverr)
    );

    // Behaviour of the execution unit behind the bus
    function automatic logic [DW-1:0] model_result(input logic [DW-1:0] op, a, b);
        case (op[1:0])
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a & b;
            default: return a ^ b;
        endcase
    endfunction

    function automatic logic [3:0] model_status(input logic [DW-1:0] r);
        return {1'b1, r == '0, r[DW-1], ^r};
    endfunction

    function automatic logic [DW-1:0] status_word(input logic [DW-1:0] r);
        return 8'hA0 | {4'h0, model_status(r)};
    endfunction

    // Index of the first log entry that differs from the job's expected bus traffic, -1 if none
    function automatic int log_mismatch(input logic [DW-1:0] op, a, b);
        xfer_t exp_q[$];
        logic [DW-1:0] r;
        r = model_result(op, a, b);
        exp_q.push_back('{0, 1'b1, op});
        exp_q.push_back('{1, 1'b1, a});
        exp_q.push_back('{2, 1'b1, b});
        exp_q.push_back('{0, 1'b0, r});
        exp_q.push_back('{1, 1'b0, status_word(r)});
        if (log_q.size() != 5) return 5;
        for (int i = 0; i < 5; i++) begin
            if (log_q[i].addr != exp_q[i].addr || log_q[i].wr != exp_q[i].wr ||
                log_q[i].data != exp_q[i].data) return i;
        end
        return -1;
    endfunction

    // Exe-unit APB slave: responds half a cycle after each rising edge
    initial begin
        int          acc_n;
        int          extra;
        bit          prev_setup;
        logic [AW-1:0] snap_addr;
        logic        snap_write;
        logic [DW-1:0] snap_wdata;
        xfer_t       t;
        acc_n = 0;
        prev_setup = 0;
        snap_addr = '0;
        snap_write = 0;
        snap_wdata = '0;
        forever begin
            @(negedge clk);
            #1;
            if (psel === 1'b1 && penable === 1'b1 && preset === 1'b0) begin
                if (acc_n == 0 && !prev_setup) stab_bad++;
                if (paddr !== snap_addr || pwrite !== snap_write || pwdata !== snap_wdata) stab_bad++;
                acc_n++;
                prev_setup = 0;
                extra = (int'(paddr) == wait_addr && pwrite == wait_write) ? wait_extra : 0;
                if (!stall && acc_n >= 2 + extra) begin
                    t.addr = int'(paddr);
                    t.wr   = pwrite;
                    if (pwrite) begin
                        t.data = int'(pwdata);
                        case (paddr)
                            16'd0:   reg_oper = pwdata;
                            16'd1:   reg_a = pwdata;
                            default: reg_b = pwdata;
                        endcase
                        prdata = 8'($urandom);
                    end else begin
                        prdata = (paddr == 16'd0) ? model_result(reg_oper, reg_a, reg_b)
                                                  : status_word(model_result(reg_oper, reg_a, reg_b));
                        t.data = int'(prdata);
                    end
                    pready  = 1'b1;
                    pslverr = slverr_en && int'(paddr) == slverr_addr && pwrite == slverr_write;
                    log_q.push_back(t);
                end else begin
                    pready  = 1'b0;
                    pslverr = 1'($urandom_range(0, 1));
                    prdata  = 8'($urandom);
                end
            end else begin
                acc_n = 0;
                prev_setup = (psel === 1'b1 && penable === 1'b0 && preset === 1'b0);
                if (prev_setup) begin
                    snap_addr  = paddr;
                    snap_write = pwrite;
                    snap_wdata = pwdata;
                end
                // Noise outside ACCESS: the master must ignore it
                pready  = 1'($urandom_range(0, 1));
                pslverr = 1'($urandom_range(0, 1));
                prdata  = 8'($urandom);
            end
        end
    end

    // Offer a command when ready; returns on the first falling edge after the accept edge
    task automatic issue_cmd(input logic [DW-1:0] op, a, b);
        int k = 0;
        log_q.delete();
        while (cmd_ready !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL cmd_ready_wait got=%b exp=1", cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_oper = op;
        cmd_arga = a;
        cmd_argb = b;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_oper = 8'($urandom);
        cmd_arga = 8'($urandom);
        cmd_argb = 8'($urandom);
    endtask

    // Falling edges after the accept edge until o_res_valid is seen (bounded)
    task automatic wait_result(output int lat);
        lat = 1;
        while (res_valid !== 1'b1 && lat < 300) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic finish_job(input int hold);
        repeat (hold) @(negedge clk);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        preset = 1'b1;
        cmd_valid = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({psel, penable, pwrite} !== 3'b000) begin
            errors++;
            $display("FAIL reset_apb_ctrl got=%b exp=000", {psel, penable, pwrite});
        end
        checks++;
        if (paddr !== '0 || pwdata !== '0) begin
            errors++;
            $display("FAIL reset_apb_bus got=%h/%h exp=0/0", paddr, pwdata);
        end
        checks++;
        if ({res_valid, res_err, res_status, res_data} !== '0) begin
            errors++;
            $display("FAIL reset_result got=%b/%b/%h/%h exp=0", res_valid, res_err, res_status, res_data);
        end
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_cmd_ready got=%b exp=0", cmd_ready);
        end
        preset = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_cmd_ready got=%b exp=1", cmd_ready);
        end
    endtask

    task automatic test_basic();
        int lat;
        int mm;
        issue_cmd(8'h01, 8'h05, 8'h03);
        wait_result(lat);
        checks++;
        if (lat != BASE_LAT) begin
            errors++;
            $display("FAIL basic_latency got=%0d exp=%0d", lat, BASE_LAT);
        end
        checks++;
        if (res_data !== model_result(8'h01, 8'h05, 8'h03) || res_status !== model_status(8'h02)) begin
            errors++;
            $display("FAIL basic_result got=%h/%h exp=%h/%h", res_data, res_status, 8'h02, model_status(8'h02));
        end
        checks++;
        if (res_err !== 1'b0) begin
            errors++;
            $display("FAIL basic_err got=%b exp=0", res_err);
        end
        mm = log_mismatch(8'h01, 8'h05, 8'h03);
        checks++;
        if (mm != -1) begin
            errors++;
            $display("FAIL basic_bus_log got=entry%0d exp=none", mm);
        end
        finish_job(0);
        checks++;
        if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_release got=%b/%b exp=0/1", res_valid, cmd_ready);
        end
    endtask

    task automatic test_wait_states();
        int lat;
        int mm;
        stab_bad = 0;
        wait_addr = 1;
        wait_write = 1;
        wait_extra = 3;
        issue_cmd(8'h01, 8'h05, 8'h03);
        wait_result(lat);
        wait_addr = 99;
        wait_extra = 0;
        checks++;
        if (lat != BASE_LAT + 3) begin
            errors++;
            $display("FAIL wait_latency got=%0d exp=%0d", lat, BASE_LAT + 3);
        end
        checks++;
        if (res_data !== 8'h02) begin
            errors++;
            $display("FAIL wait_result got=%h exp=02", res_data);
        end
        checks++;
        if (stab_bad != 0) begin
            errors++;
            $display("FAIL wait_stability got=%0d exp=0", stab_bad);
        end
        mm = log_mismatch(8'h01, 8'h05, 8'h03);
        checks++;
        if (mm != -1) begin
            errors++;
            $display("FAIL wait_bus_log got=entry%0d exp=none", mm);
        end
        finish_job(1);
    endtask

    task automatic test_random();
        int lat;
        int mm;
        int ex;
        logic [DW-1:0] op, a, b, r;
        stab_bad = 0;
        for (int j = 0; j < 8; j++) begin
            op = 8'($urandom);
            a  = 8'($urandom);
            b  = 8'($urandom);
            r  = model_result(op, a, b);
            ex = $urandom_range(0, 3);
            wait_addr  = $urandom_range(0, 2);
            wait_write = 1'($urandom_range(0, 1));
            if (!wait_write && wait_addr == 2) wait_addr = 0;
            wait_extra = ex;
            issue_cmd(op, a, b);
            wait_result(lat);
            checks++;
            if (lat != BASE_LAT + ex) begin
                errors++;
                $display("FAIL rand%0d_latency got=%0d exp=%0d", j, lat, BASE_LAT + ex);
            end
            checks++;
            if (res_data !== r || res_status !== model_status(r) || res_err !== 1'b0) begin
                errors++;
                $display("FAIL rand%0d_result got=%h/%h/%b exp=%h/%h/0", j, res_data, res_status, res_err, r, model_status(r));
            end
            mm = log_mismatch(op, a, b);
            checks++;
            if (mm != -1) begin
                errors++;
                $display("FAIL rand%0d_bus_log got=entry%0d exp=none", j, mm);
            end
            finish_job($urandom_range(0, 3));
        end
        wait_addr = 99;
        wait_extra = 0;
        checks++;
        if (stab_bad != 0) begin
            errors++;
            $display("FAIL rand_stability got=%0d exp=0", stab_bad);
        end
    endtask

    task automatic test_slverr();
        int lat;
        slverr_en = 1;
        slverr_addr = 0;
        slverr_write = 0;
        issue_cmd(8'h02, 8'h3C, 8'h0F);
        wait_result(lat);
        slverr_en = 0;
        checks++;
        if (lat != BASE_LAT || res_err !== 1'b1) begin
            errors++;
            $display("FAIL slverr_done got=lat%0d/err%b exp=lat%0d/err1", lat, res_err, BASE_LAT);
        end
        checks++;
        if (res_data !== 8'h0C) begin
            errors++;
            $display("FAIL slverr_result got=%h exp=0c", res_data);
        end
        finish_job(0);
        issue_cmd(8'h00, 8'h10, 8'h20);
        wait_result(lat);
        checks++;
        if (res_err !== 1'b0 || res_data !== 8'h30) begin
            errors++;
            $display("FAIL slverr_next_job got=%b/%h exp=0/30", res_err, res_data);
        end
        finish_job(0);
    endtask

    task automatic test_done_hold();
        int lat;
        logic [DW-1:0] snap_d;
        logic [3:0]    snap_s;
        issue_cmd(8'h03, 8'hF0, 8'h55);
        wait_result(lat);
        snap_d = res_data;
        snap_s = res_status;
        checks++;
        if (snap_d !== 8'hA5) begin
            errors++;
            $display("FAIL hold_result got=%h exp=a5", snap_d);
        end
        for (int c = 0; c < 5; c++) begin
            cmd_valid = 1'b1;
            cmd_oper = 8'($urandom);
            cmd_arga = 8'($urandom);
            cmd_argb = 8'($urandom);
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b1 || res_data !== snap_d || res_status !== snap_s ||
                cmd_ready !== 1'b0 || psel !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle%0d got=v%b d%h s%h rdy%b sel%b exp=v1 d%h s%h rdy0 sel0",
                         c, res_valid, res_data, res_status, cmd_ready, psel, snap_d, snap_s);
            end
        end
        cmd_valid = 1'b0;
        finish_job(0);
        checks++;
        if (log_q.size() != 5) begin
            errors++;
            $display("FAIL hold_no_new_xfers got=%0d exp=5", log_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        int k = 0;
        int lat;
        bit any_valid = 0;
        issue_cmd(8'h00, 8'h11, 8'h22);
        while (k < 100) begin
            if (psel === 1'b1 && penable === 1'b1 && pwrite === 1'b1 && paddr === 16'd2) begin
                seen++;
                if (seen == 2) break;
            end
            @(negedge clk);
            k++;
        end
        checks++;
        if (seen != 2) begin
            errors++;
            $display("FAIL midreset_reach_access got=%0d exp=2", seen);
        end
        preset = 1'b1;
        @(negedge clk);
        preset = 1'b0;
        checks++;
        if (psel !== 1'b0 || penable !== 1'b0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_abort got=%b%b%b exp=000", psel, penable, res_valid);
        end
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (res_valid !== 1'b0) any_valid = 1;
        end
        checks++;
        if (any_valid || cmd_ready !== 1'b1 || log_q.size() != 2) begin
            errors++;
            $display("FAIL midreset_idle got=v%b rdy%b xfers%0d exp=v0 rdy1 xfers2", any_valid, cmd_ready, log_q.size());
        end
        issue_cmd(8'h01, 8'h40, 8'h01);
        wait_result(lat);
        checks++;
        if (lat != BASE_LAT || res_data !== 8'h3F || res_err !== 1'b0) begin
            errors++;
            $display("FAIL midreset_next_job got=lat%0d/%h/%b exp=lat%0d/3f/0", lat, res_data, res_err, BASE_LAT);
        end
        finish_job(0);
    endtask

`ifdef APB_MST_TIMEOUT_EN
    task automatic test_timeout();
        int n_acc = 0;
        int k = 0;
        stall = 1;
        issue_cmd(8'h01, 8'h09, 8'h04);
        while (k < 100) begin
            if (psel === 1'b1 && penable === 1'b1) n_acc++;
            else if (n_acc > 0) break;
            @(negedge clk);
            k++;
        end
        stall = 0;
        checks++;
        if (n_acc != TIMEOUT) begin
            errors++;
            $display("FAIL timeout_access_cycles got=%0d exp=%0d", n_acc, TIMEOUT);
        end
        checks++;
        if (res_valid !== 1'b1 || res_err !== 1'b1 || res_data !== '0 || res_status !== '0) begin
            errors++;
            $display("FAIL timeout_done got=v%b e%b d%h s%h exp=v1 e1 d00 s0", res_valid, res_err, res_data, res_status);
        end
        finish_job(0);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_wait_states();
        test_random();
        test_slverr();
        test_done_hold();
        test_reset_mid();
`ifdef APB_MST_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
